// File: rtl/ins_prefetch.sv
// Instruction prefetch unit: fetches longwords from local memory and queues
// 16-bit instruction words with their byte addresses for the decoder.
module ins_prefetch #(
    parameter int QDEPTH = 4,
    parameter int AW     = 24
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          go,
    input  logic          pcload,
    input  logic [AW-1:0] pc_in,
    output logic          fetch_req,
    output logic [AW-3:0] fetch_addr,
    input  logic          fetch_ack,
    input  logic [31:0]   fetch_data,
    output logic          insrdy,
    output logic [15:0]   ins_out,
    output logic [AW-1:0] ins_pc,
    input  logic          romold
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        DISCARD = 2'b10
    } state_t;

    state_t        state_r;
    logic          fetch_req_r;
    logic [AW-3:0] addr_r;
    logic [AW-3:0] held_r;
    logic          align_r;

    logic [15:0]   word_q_r [QDEPTH];
    logic [AW-1:0] pc_q_r   [QDEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          insrdy_r;

    logic          accept_s;
    logic          pop_s;
    logic [1:0]    wr_n_s;
    logic [CW-1:0] count_nxt_s;
    logic          can_issue_s;
    logic          unused_s;

    assign unused_s = pc_in[0];

    // Queue write/pop decode and next occupancy
    always_comb begin
        accept_s    = 1'b0;
        wr_n_s      = 2'd0;
        pop_s       = 1'b0;
        count_nxt_s = count_r;
        can_issue_s = 1'b0;

        // Data is kept only for a live request that is not being flushed
        accept_s = (state_r == REQ) && fetch_ack && !pcload;
        if (accept_s) begin
            if (align_r) begin
                wr_n_s = 2'd1;
            end else begin
                wr_n_s = 2'd2;
            end
        end else begin
            wr_n_s = 2'd0;
        end

        pop_s = romold && insrdy_r && !pcload;

        if (pcload) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            count_nxt_s = count_r - CW'(pop_s) + CW'(wr_n_s);
        end

        // Two free slots guarantee the returning longword always fits
        can_issue_s = go && !pcload && (count_r <= CW'(QDEPTH - 2));
    end

    // Fetch FSM with registered request and address
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_r     <= IDLE;
            fetch_req_r <= 1'b0;
            addr_r      <= {(AW-2){1'b0}};
            held_r      <= {(AW-2){1'b0}};
            align_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pcload) begin
                        addr_r  <= pc_in[AW-1:2];
                        align_r <= pc_in[1];
                    end else if (can_issue_s) begin
                        state_r     <= REQ;
                        fetch_req_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (fetch_ack) begin
                        state_r     <= IDLE;
                        fetch_req_r <= 1'b0;
                        if (pcload) begin
                            addr_r  <= pc_in[AW-1:2];
                            align_r <= pc_in[1];
                        end else begin
                            addr_r  <= addr_r + (AW-2)'(1);
                            align_r <= 1'b0;
                        end
                    end else if (pcload) begin
                        // Request must still complete at the stale address
                        state_r <= DISCARD;
                        held_r  <= pc_in[AW-1:2];
                        align_r <= pc_in[1];
                    end
                end
                DISCARD: begin
                    if (fetch_ack) begin
                        state_r     <= IDLE;
                        fetch_req_r <= 1'b0;
                        if (pcload) begin
                            addr_r  <= pc_in[AW-1:2];
                            align_r <= pc_in[1];
                        end else begin
                            addr_r  <= held_r;
                        end
                    end else if (pcload) begin
                        held_r  <= pc_in[AW-1:2];
                        align_r <= pc_in[1];
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    fetch_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Circular word queue with byte-address tags
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            insrdy_r <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                word_q_r[i] <= 16'h0000;
                pc_q_r[i]   <= {AW{1'b0}};
            end
        end else begin
            if (pcload) begin
                rd_ptr_r <= {PW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
            end else begin
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
                case (wr_n_s)
                    2'd2: begin
                        word_q_r[wr_ptr_r]          <= fetch_data[31:16];
                        pc_q_r[wr_ptr_r]            <= {addr_r, 2'b00};
                        word_q_r[wr_ptr_r + PW'(1)] <= fetch_data[15:0];
                        pc_q_r[wr_ptr_r + PW'(1)]   <= {addr_r, 2'b10};
                        wr_ptr_r                    <= wr_ptr_r + PW'(2);
                    end
                    2'd1: begin
                        word_q_r[wr_ptr_r] <= fetch_data[15:0];
                        pc_q_r[wr_ptr_r]   <= {addr_r, 2'b10};
                        wr_ptr_r           <= wr_ptr_r + PW'(1);
                    end
                    default: begin
                        wr_ptr_r <= wr_ptr_r;
                    end
                endcase
            end
            count_r  <= count_nxt_s;
            insrdy_r <= (count_nxt_s != {CW{1'b0}});
        end
    end

    assign fetch_req  = fetch_req_r;
    assign fetch_addr = addr_r;
    assign insrdy     = insrdy_r;
    assign ins_out    = word_q_r[rd_ptr_r];
    assign ins_pc     = pc_q_r[rd_ptr_r];

endmodule
